m31_sqrt: RTL and testbench

//  Iterative square root over M31 (P_M31 = 2^31-1), the inverse of the m31_sqr squaring unit.
//  P_M31 = 3 mod 4, so root r = a^((P+1)/4) = a^(2^29): ITER=29 chained squarings.
//  An optional final squaring checks r*r == a, flagging quadratic non-residues.

---
 rtl/m31_sqrt.sv | 224 ++++++++++++++++++++++
 tb/tb_m31_sqrt.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m31_sqrt.sv
// m31_sqrt: iterative square root over M31 (P = 2^31-1), computed as r = a^(2^29)
// through 29 chained squarings on an internal pipelined m31_sqr unit.
// Build option: define M31_SQRT_CHECK_EN to add a final squaring that compares
// r*r against a. Non-residues then report root_o=0 and is_qr_o=0.
// With the macro undefined there is no check, latency is 118 cycles, and is_qr_o=1.

// Pipelined modular squarer, LAT cycles from operand presented to result valid.
module m31_sqr #(
    parameter int LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [30:0] a,
    output logic        out_valid,
    output logic [30:0] y
);
    localparam logic [30:0] P_M31 = 31'h7fff_ffff;

    logic [LAT-1:0] vld;
    logic [30:0]    a_q;
    logic [61:0]    prod_q;
    logic [31:0]    fold;
    logic [30:0]    red;
    logic [30:0]    red_q [LAT-2];

    // Valid token pipeline; clearing it on reset discards every in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state always uses non-blocking assignment so every rank samples pre-edge values.
        if (!rst_n) vld <= '0;
        else        vld <= {vld[LAT-2:0], in_valid};
    end

    // Stage 1 captures the operand, stage 2 forms the full 62-bit product.
    always_ff @(posedge clk) begin
        // NOTE: datapath ranks have no reset; only the valid token must be defined after reset.
        a_q    <= a;
        prod_q <= {31'd0, a_q} * {31'd0, a_q};
    end

    // 2^31 == 1 mod P, so the high half folds onto the low half; one subtract is enough.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        fold = {1'b0, prod_q[30:0]} + {1'b0, prod_q[61:31]};
        red  = fold[30:0];
        if (fold >= {1'b0, P_M31}) red = 31'(fold - {1'b0, P_M31});
    end

    // Remaining ranks delay the reduced value so the unit totals LAT cycles.
    always_ff @(posedge clk) begin
        red_q[0] <= red;
        for (int i = 1; i < LAT - 2; i++) red_q[i] <= red_q[i-1];
    end

    assign out_valid = vld[LAT-1];
    assign y         = red_q[LAT-3];
endmodule

// Square-root controller: one op at a time, exactly one squaring in flight.
module m31_sqrt (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [30:0] a_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [30:0] root_o,
    output logic        is_qr_o
);
    localparam int          ITER    = 29;
    localparam int          SQR_LAT = 4;
    localparam logic [30:0] P_M31   = 31'h7fff_ffff;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SQR,
`ifdef M31_SQRT_CHECK_EN
        S_CHK,
`endif
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [30:0] x;
    logic [4:0]  cnt;
    logic        busy;      // first squaring of the op has been issued
    logic        fin;       // result known; one cycle to canonicalise before DONE
    logic        last;
    logic [30:0] a_canon;
    logic [30:0] neg;
    logic [30:0] low;
    logic        sq_v;
    logic [30:0] sq_a;
    logic        sq_ov;
    logic [30:0] sq_y;
`ifdef M31_SQRT_CHECK_EN
    logic [30:0] a_q;
    logic        qr_q;
`endif

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign last      = (cnt == 5'(ITER - 1));
    assign a_canon   = (a_i == P_M31) ? '0 : a_i;
    // r and P-r are the two roots; P-r is a plain 31-bit subtract (r=0 gives P, so min stays 0).
    assign neg       = P_M31 - x;
    assign low       = (neg < x) ? neg : x;

    m31_sqr #(
        .LAT (SQR_LAT)
    ) u_sqr (
        .clk       (clk),
        .rst_n     (~rst),
        .in_valid  (sq_v),
        .a         (sq_a),
        .out_valid (sq_ov),
        .y         (sq_y)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next state and squarer issue; results are chained straight back into the squarer.
    always_comb begin
        state_nx = state;
        sq_v     = 1'b0;
        sq_a     = x;
        case (state)
            S_IDLE: begin
                if (in_valid) state_nx = S_SQR;
            end
            S_SQR: begin
                if (!busy) begin
                    sq_v = 1'b1;
                end else if (sq_ov && !last) begin
                    sq_v = 1'b1;
                    sq_a = sq_y;
                end
`ifdef M31_SQRT_CHECK_EN
                if (sq_ov && last) begin
                    sq_v     = 1'b1;
                    sq_a     = sq_y;
                    state_nx = S_CHK;
                end
`else
                if (fin) state_nx = S_DONE;
`endif
            end
`ifdef M31_SQRT_CHECK_EN
            S_CHK: begin
                if (fin) state_nx = S_DONE;
            end
`endif
            S_DONE: begin
                if (out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Operand, iteration count and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            x       <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            fin     <= 1'b0;
            root_o  <= '0;
            is_qr_o <= 1'b0;
`ifdef M31_SQRT_CHECK_EN
            a_q     <= '0;
            qr_q    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x    <= a_canon;
                        cnt  <= '0;
                        busy <= 1'b0;
                        fin  <= 1'b0;
`ifdef M31_SQRT_CHECK_EN
                        a_q  <= a_canon;
`endif
                    end
                end
                S_SQR: begin
                    if (!busy) busy <= 1'b1;
                    if (sq_ov) begin
                        x   <= sq_y;
                        cnt <= cnt + 5'd1;
`ifndef M31_SQRT_CHECK_EN
                        if (last) fin <= 1'b1;
`endif
                    end
`ifndef M31_SQRT_CHECK_EN
                    if (fin) begin
                        root_o  <= low;
                        is_qr_o <= 1'b1;
                    end
`endif
                end
`ifdef M31_SQRT_CHECK_EN
                S_CHK: begin
                    if (sq_ov) begin
                        qr_q <= (sq_y == a_q);
                        fin  <= 1'b1;
                    end
                    if (fin) begin
                        root_o  <= qr_q ? low : '0;
                        is_qr_o <= qr_q;
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_m31_sqrt.sv
// Bench for m31_sqrt: directed spec vectors, random squares and random operands
// checked against an exponentiation model, handshake, busy-pulse and mid-op reset scenarios.
`timescale 1ns/1ps
module tb_m31_sqrt;
    localparam logic [30:0]     P  = 31'h7fff_ffff;
    localparam longint unsigned PL = 64'h7fff_ffff;
`ifdef M31_SQRT_CHECK_EN
    localparam int EXP_LAT = 122;
`else
    localparam int EXP_LAT = 118;
`endif
    localparam int TIMEOUT = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [30:0] a_i = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [30:0] root_o;
    logic        is_qr_o;

    int errors = 0;
    int checks = 0;

    m31_sqrt dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_i       (a_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .root_o    (root_o),
        .is_qr_o   (is_qr_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic longint unsigned mulmod(input longint unsigned a, input longint unsigned b);
        return (a * b) % PL;
    endfunction

    // Reference: r = a^((P+1)/4) by plain modular arithmetic; returns {is_qr, root}.
    function automatic logic [31:0] model(input logic [30:0] a);
        longint unsigned ac, r, lo;
        bit              qr;
        ac = (a == P) ? 64'd0 : {33'd0, a};
        r  = ac;
        for (int i = 0; i < 29; i++) r = mulmod(r, r);
        lo = (r == 0) ? 64'd0 : ((PL - r < r) ? PL - r : r);
        qr = (mulmod(r, r) == ac);
`ifdef M31_SQRT_CHECK_EN
        if (!qr) lo = 64'd0;
        return {qr, lo[30:0]};
`else
        return {1'b1, lo[30:0]};
`endif
    endfunction

    // Drive one op, wait (bounded) for the result, take it with a one-cycle out_ready.
    task automatic run_op(input logic [30:0] a, output logic [30:0] r, output logic q, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        a_i      = a;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < TIMEOUT) begin
            @(posedge clk); #1;
            lat++;
        end
        r = root_o;
        q = is_qr_o;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL op_timeout a=%0d got out_valid=%b after %0d cycles want=1", a, out_valid, lat);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || root_o !== 31'd0 || is_qr_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got in_ready=%b out_valid=%b root=%0d qr=%b want 1 0 0 0",
                     in_ready, out_valid, root_o, is_qr_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_known();
        logic [30:0] a_list [6];
        logic [30:0] r_list [6];
        logic        q_list [6];
        logic [30:0] r;
        logic        q;
        int          lat;
        a_list = '{31'd4, 31'd2, 31'd9, 31'd0, P, P - 31'd1};
        r_list = '{31'd2, 31'd65536, 31'd3, 31'd0, 31'd0, 31'd0};
        q_list = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`ifndef M31_SQRT_CHECK_EN
        r_list[5] = 31'd1;
        q_list[5] = 1'b1;
`endif
        for (int i = 0; i < 6; i++) begin
            run_op(a_list[i], r, q, lat);
            checks++;
            if (r !== r_list[i] || q !== q_list[i]) begin
                errors++;
                $display("FAIL known_root a=%0d got root=%0d qr=%b want root=%0d qr=%b",
                         a_list[i], r, q, r_list[i], q_list[i]);
            end
            checks++;
            if (lat !== EXP_LAT) begin
                errors++;
                $display("FAIL known_latency a=%0d got=%0d want=%0d", a_list[i], lat, EXP_LAT);
            end
        end
    endtask

    task automatic test_squares();
        longint unsigned s, a, want;
        logic [30:0]     r;
        logic            q;
        int              lat;
        for (int i = 0; i < 8; i++) begin
            s = (i == 0) ? PL - 2 : longint'($urandom_range(32'h7fff_fffe, 32'd1));
            a = mulmod(s, s);
            want = (PL - s < s) ? PL - s : s;
            run_op(a[30:0], r, q, lat);
            checks++;
            if (r !== want[30:0] || q !== 1'b1 || lat !== EXP_LAT) begin
                errors++;
                $display("FAIL square_root s=%0d a=%0d got root=%0d qr=%b lat=%0d want root=%0d qr=1 lat=%0d",
                         s, a, r, q, lat, want, EXP_LAT);
            end
        end
    endtask

    task automatic test_random();
        logic [30:0] a;
        logic [31:0] exp_v;
        logic [30:0] r;
        logic        q;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            a = 31'($urandom_range(32'h7fff_ffff, 32'd0));
            exp_v = model(a);
            run_op(a, r, q, lat);
            checks++;
            if (r !== exp_v[30:0] || q !== exp_v[31]) begin
                errors++;
                $display("FAIL random_op a=%0d got root=%0d qr=%b want root=%0d qr=%b",
                         a, r, q, exp_v[30:0], exp_v[31]);
            end
        end
    endtask

    task automatic test_hold_and_ignore();
        int lat;
        bit spurious;
        @(negedge clk);
        in_valid = 1'b1;
        a_i      = 31'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        a_i      = 31'd4;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_ready got=%b want=0", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 21;
        while (!out_valid && lat < TIMEOUT) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1 || lat !== EXP_LAT) begin
            errors++;
            $display("FAIL hold_latency got out_valid=%b lat=%0d want 1 lat=%0d", out_valid, lat, EXP_LAT);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || root_o !== 31'd3 || is_qr_o !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable cycle=%0d got out_valid=%b root=%0d qr=%b in_ready=%b want 1 3 1 0",
                         i, out_valid, root_o, is_qr_o, in_ready);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL handshake_cycle_in_ready got=%b want=0", in_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_handshake got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        spurious = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            if (out_valid) spurious = 1'b1;
        end
        checks++;
        if (spurious !== 1'b0) begin
            errors++;
            $display("FAIL busy_pulse_queued got out_valid seen=%b want=0", spurious);
        end
    endtask

    task automatic test_back_to_back();
        logic [30:0] a_list [3];
        logic [30:0] r_list [3];
        logic [30:0] r;
        logic        q;
        int          lat;
        a_list = '{31'd9, 31'd4, 31'd16};
        r_list = '{31'd3, 31'd2, 31'd4};
        for (int i = 0; i < 3; i++) begin
            run_op(a_list[i], r, q, lat);
            checks++;
            if (r !== r_list[i] || q !== 1'b1 || lat !== EXP_LAT) begin
                errors++;
                $display("FAIL back_to_back a=%0d got root=%0d qr=%b lat=%0d want root=%0d qr=1 lat=%0d",
                         a_list[i], r, q, lat, r_list[i], EXP_LAT);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [30:0] r;
        logic        q;
        int          lat;
        @(negedge clk);
        in_valid = 1'b1;
        a_i      = 31'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (49) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(31'd9, r, q, lat);
        checks++;
        if (r !== 31'd3 || q !== 1'b1 || lat !== EXP_LAT) begin
            errors++;
            $display("FAIL after_reset_op got root=%0d qr=%b lat=%0d want root=3 qr=1 lat=%0d",
                     r, q, lat, EXP_LAT);
        end
    endtask

    initial begin
        test_reset();
        test_known();
        test_squares();
        test_random();
        test_hold_and_ignore();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
